// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-addressed data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << off;
      SZ_HALF: lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_be_ram.sv
// Word array with per-byte write enables; synchronous write, asynchronous read, no reset.
module dmem_be_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [3:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[waddr][b] <= wdata[8*b +: 8];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store controller: clear sweep after reset, fixed-latency
// access with wait states, lane alignment and sign/zero extension of loads.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_W      = 6,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] INIT_VAL    = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [3:0]        wait_cnt;
  req_t              rq;
  logic [ADDR_W-1:0] rq_idx;
  logic              rq_err;

  req_t              cur;
  logic [ADDR_W-1:0] cur_idx;
  logic              cur_err;
  logic              accept;
  logic              enter_resp;

  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  assign accept = req_valid && req_ready && (state == ST_IDLE);

  // With no wait states the commit edge is the accept edge, so use the live request.
  always_comb begin
    cur     = rq;
    cur_idx = rq_idx;
    if (state == ST_IDLE) begin
      cur     = '{we: req_we, size: req_size, uns: req_unsigned,
                  off: req_addr[1:0], wdata: req_wdata};
      cur_idx = req_addr[ADDR_W+1:2];
    end
  end

  assign cur_err    = misaligned(cur.size, cur.off);
  assign rq_err     = misaligned(rq.size, rq.off);
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == 4'd0));

  always_comb begin
    ram_we    = 4'b0000;
    ram_waddr = cur_idx;
    case (cur.size)
      SZ_BYTE: ram_wdata = {4{cur.wdata[7:0]}};
      SZ_HALF: ram_wdata = {2{cur.wdata[15:0]}};
      default: ram_wdata = cur.wdata;
    endcase
    if (state == ST_CLEAR) begin
      ram_we    = 4'b1111;
      ram_waddr = clr_ptr;
      ram_wdata = INIT_VAL;
    end else if (enter_resp && cur.we && !cur_err) begin
      ram_we = lane_be(cur.size, cur.off);
    end
  end

  dmem_be_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rq_idx),
    .rdata (ram_rdata)
  );

  assign shifted = ram_rdata >> {rq.off, 3'b000};

  always_comb begin
    case (rq.size)
      SZ_BYTE: load_val = {{24{~rq.uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = {{16{~rq.uns & shifted[15]}}, shifted[15:0]};
      default: load_val = ram_rdata;
    endcase
  end

  // After RESP the FSM sits one cycle in IDLE with req_ready low while the
  // registered response is on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      wait_cnt  <= '0;
      rq        <= '0;
      rq_idx    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            rq        <= cur;
            rq_idx    <= cur_idx;
            req_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 1'b1;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= rq_err;
          rsp_rdata <= (rq_err || rq.we) ? 32'd0 : load_val;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: expected responses queued at acceptance, compared on rsp_valid.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int ADDR_W = 6;
  localparam int WAIT   = 3;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) chk("unexp_rsp", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rdata", rsp_rdata, e.rdata);
        chk("err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("latency", 32'(cyc - e.acc), 32'(WAIT + 1));
      end
    end
  end

  task automatic wait_clear();
    int n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("clr_cycles", 32'(n), 32'd64);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int   n = 0;
    exp_t x;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    x.rdata = exp_rdata; x.err = exp_err; x.acc = cyc;
    q.push_back(x);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      chk("rsp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    issue(we, size, uns, addr, wdata, exp_rdata, exp_err);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    wait_clear();

    xact(1'b0, SZ_WORD, 1'b0, 8'h00, 32'd0, INIT, 1'b0);

    // byte store then extension variants
    xact(1'b1, SZ_BYTE, 1'b0, 8'h05, 32'h00000080, 32'd0, 1'b0);
    xact(1'b0, SZ_BYTE, 1'b0, 8'h05, 32'd0, 32'hFFFFFF80, 1'b0);
    xact(1'b0, SZ_BYTE, 1'b1, 8'h05, 32'd0, 32'h00000080, 1'b0);
    xact(1'b0, SZ_WORD, 1'b0, 8'h04, 32'd0, 32'hFFFF80FF, 1'b0);

    // half store, upper bits of wdata must be ignored
    xact(1'b1, SZ_HALF, 1'b0, 8'h0A, 32'hABCD1234, 32'd0, 1'b0);
    xact(1'b0, SZ_WORD, 1'b0, 8'h08, 32'd0, 32'h1234FFFF, 1'b0);
    xact(1'b0, SZ_HALF, 1'b0, 8'h0A, 32'd0, 32'h00001234, 1'b0);
    xact(1'b0, SZ_HALF, 1'b0, 8'h08, 32'd0, 32'hFFFFFFFF, 1'b0);
    xact(1'b0, SZ_HALF, 1'b1, 8'h08, 32'd0, 32'h0000FFFF, 1'b0);

    // word store and sub-word loads at each offset
    xact(1'b1, SZ_WORD, 1'b0, 8'h20, 32'h89ABCDEF, 32'd0, 1'b0);
    xact(1'b0, SZ_HALF, 1'b0, 8'h22, 32'd0, 32'hFFFF89AB, 1'b0);
    xact(1'b0, SZ_BYTE, 1'b1, 8'h21, 32'd0, 32'h000000CD, 1'b0);
    xact(1'b0, SZ_BYTE, 1'b0, 8'h23, 32'd0, 32'hFFFFFF89, 1'b0);
    xact(1'b0, SZ_BYTE, 1'b0, 8'hFC, 32'd0, 32'hFFFFFFFF, 1'b0);

    // errors leave memory untouched
    xact(1'b1, SZ_WORD, 1'b0, 8'h02, 32'h00000000, 32'd0, 1'b1);
    xact(1'b0, 2'd3,    1'b0, 8'h00, 32'd0, 32'd0, 1'b1);
    xact(1'b1, SZ_HALF, 1'b0, 8'h09, 32'h00000000, 32'd0, 1'b1);
    xact(1'b0, SZ_HALF, 1'b0, 8'h23, 32'd0, 32'd0, 1'b1);
    xact(1'b0, SZ_WORD, 1'b0, 8'h00, 32'd0, INIT, 1'b0);
    xact(1'b0, SZ_WORD, 1'b0, 8'h08, 32'd0, 32'h1234FFFF, 1'b0);

    // cycle-by-cycle latency and ready profile
    issue(1'b0, SZ_WORD, 1'b0, 8'h08, 32'd0, 32'h1234FFFF, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("lat_valid_k%0d", k), {31'd0, rsp_valid}, {31'd0, k == WAIT + 1});
      chk($sformatf("lat_ready_k%0d", k), {31'd0, req_ready}, {31'd0, k == WAIT + 2});
    end
    drain();

    // reset during WAIT of a store aborts it and reruns the sweep
    issue(1'b1, SZ_WORD, 1'b0, 8'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rdata", rsp_rdata, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_valid2", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    wait_clear();
    xact(1'b0, SZ_WORD, 1'b0, 8'h10, 32'd0, INIT, 1'b0);
    xact(1'b0, SZ_WORD, 1'b0, 8'h04, 32'd0, INIT, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving word-address bits (depth 2**ADDR_W words of 32 bits).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, range 0..15, giving extra access wait states.
REQ-003 The block SHALL have parameter INIT_VAL, default 32'hFFFFFFFF, giving the word value written by the clear sweep.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 illegal.
REQ-010 The block SHALL have port req_unsigned, input, 1 bit: zero-extend on sub-word loads.
REQ-011 The block SHALL have port req_addr, input, ADDR_W+2 bits: byte address.
REQ-012 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port rsp_rdata, output, 32 bits: extended load data.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: misaligned or illegal-size request.

Function
REQ-016 The FSM SHALL use states CLEAR, IDLE, WAIT and RESP.
REQ-017 CLEAR SHALL write INIT_VAL to word 0 through word 2**ADDR_W-1, one word per cycle; then go to IDLE.
REQ-018 req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; all request fields are captured at that edge.
REQ-020 After acceptance the FSM SHALL go to WAIT if WAIT_CYCLES>0, else straight to RESP.
REQ-021 The FSM SHALL stay in WAIT exactly WAIT_CYCLES cycles, using a down-counter.
REQ-022 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-023 Response timing SHALL be: accepted at edge T, rsp_valid high in the cycle after edge T+1+WAIT_CYCLES.
REQ-024 No new request SHALL be accepted until IDLE is reached, so there is at most one outstanding request.
REQ-025 Alignment rule: half requires addr[0]=0; word requires addr[1:0]=0; size 3 is always an error.
REQ-026 On an error, the block SHALL NOT write memory, SHALL return rsp_err=1 and rsp_rdata=0, and SHALL keep the same latency.
REQ-027 Stores SHALL be little-endian with byte offset addr[1:0]:
- byte: write lane addr[1:0] with wdata[7:0];
- half: write lanes offset and offset+1 with wdata[15:0];
- word: write all 4 lanes.
Other lanes SHALL be unchanged.
REQ-028 The store commit SHALL occur on the edge that enters RESP.
REQ-029 A store response SHALL give rsp_rdata=0.
REQ-030 Loads SHALL select the addressed byte or half, then sign-extend (req_unsigned=0) or zero-extend (req_unsigned=1); a word load is returned unmodified.
REQ-031 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-032 Address arithmetic SHALL be word index = addr[ADDR_W+1:2]; there is no out-of-range case.

Reset
REQ-033 While rst_n=0, the outputs SHALL be req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-034 While rst_n=0, the state SHALL be CLEAR with the clear pointer at 0 and the wait counter at 0.
REQ-035 Reset asserted mid-operation SHALL abort any request (no response is produced); a store SHALL commit only if RESP had already been entered.
REQ-036 The storage array SHALL NOT be directly reset; its contents are defined only by the post-reset CLEAR sweep.

Structure
REQ-037 Package dmem_pkg SHALL hold the size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the FSM state enum.
REQ-038 Sub-module dmem_be_ram SHALL hold a parametrised byte-enable synchronous-write, asynchronous-read array.
REQ-039 The lane alignment and extension logic SHALL be implemented in dmem_ctrl.

Verification
REQ-040 Scenario, reset and clear: release rst_n -> req_ready=0 for 64 cycles, then 1; a word load of addr 0x00 -> rdata 0xFFFFFFFF.
REQ-041 Scenario, byte store and signed load: store byte 0x80 at 0x05, then signed byte load of 0x05 -> rdata 0xFFFFFF80; unsigned -> 0x00000080; word load of 0x04 -> 0xFFFF80FF.
REQ-042 Scenario, half store: store half 0x1234 at 0x0A, then word load of 0x08 -> 0x1234FFFF.
REQ-043 Scenario, latency: WAIT_CYCLES=3, request accepted at edge T -> rsp_valid only in the cycle after edge T+4, and req_ready=0 throughout.
REQ-044 Scenario, errors: word store at 0x02, then size-3 load -> rsp_err=1 both times with rdata=0; memory unchanged.
REQ-045 Scenario, reset abort: assert rst_n during WAIT of a store -> no rsp_valid, the CLEAR sweep reruns, and a load returns INIT_VAL.
